// File: rtl/seq_detector_prog_if.sv
// Serial-bit and configuration bundle for seq_detector_prog.
// The bench (or upstream logic) drives through master; the detector sits on slave.
interface seq_detector_prog_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic               in_valid;
  logic               x;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               z;
  logic               cfg_err;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output in_valid, x, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    input  z, cfg_err, match_cnt
  );

  modport slave (
    input  in_valid, x, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    output z, cfg_err, match_cnt
  );
endinterface

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector (1..MAX_LEN bits, overlap selectable).
// Define SEQ_DETECTOR_MATCH_COUNT_EN to build the saturating match counter; otherwise match_cnt=0.
module seq_detector_prog #(
  parameter int unsigned         MAX_LEN     = 8,
  parameter logic [MAX_LEN-1:0]  DEF_PATTERN = 8'b0000_1011,
  parameter int unsigned         DEF_LEN     = 4,
  parameter bit                  DEF_OVERLAP = 1'b0,
  parameter int unsigned         CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_detector_prog_if.slave   bus
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               z_q, z_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_plus1;
  logic               hit;
  logic               len_ok;

  // Candidate window is the history with the incoming bit appended; mask keeps the low len bits.
  always_comb begin
    cand = {hist_q[MAX_LEN-2:0], bus.x};
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (int'(len_q) > i);
    end
    fill_plus1 = {1'b0, fill_q} + (LEN_W + 1)'(1);
    hit        = (((cand ^ pat_q) & mask) == '0) && (fill_plus1 >= {1'b0, len_q});
    len_ok     = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    z_d    = 1'b0;
    err_d  = 1'b0;
    if (bus.cfg_load) begin
      // The x bit on a load cycle is always dropped, accepted load or not.
      if (len_ok) begin
        pat_d  = bus.cfg_pattern;
        len_d  = bus.cfg_len;
        ovl_d  = bus.cfg_overlap;
        hist_d = '0;
        fill_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.in_valid) begin
      hist_d = cand;
      z_d    = hit;
      if (hit && !ovl_q) begin
        fill_d = '0;
      end else if (fill_q != LEN_W'(MAX_LEN)) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEF_PATTERN;
      len_q  <= LEN_W'(DEF_LEN);
      ovl_q  <= DEF_OVERLAP;
      z_q    <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      z_q    <= z_d;
      err_q  <= err_d;
    end
  end

  assign bus.z       = z_q;
  assign bus.cfg_err = err_q;

`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (z_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.match_cnt = cnt_q;
`else
  assign bus.match_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog: directed scenarios plus randomized traffic
// compared against a bit-queue reference model.
module tb_seq_detector_prog;
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  seq_detector_prog_if #(.MAX_LEN(8), .CNT_W(16)) bus ();
  seq_detector_prog_if #(.MAX_LEN(8), .CNT_W(2))  bus2 ();

  seq_detector_prog #(.CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  seq_detector_prog #(.CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;

  // Reference model: bits received since the last clear, compared at the tail.
  bit        mq[$];
  bit [7:0]  m_pat;
  int        m_len;
  bit        m_ovl;
  int        m_cnt;
  logic        exp_z;
  logic        exp_err;
  logic [15:0] exp_cnt;

  task automatic model_step(input bit rst, input bit ld, input bit [3:0] clen,
                            input bit [7:0] cpat, input bit covl, input bit v, input bit xb);
    bit hitm;
    int n;
    exp_z   = 1'b0;
    exp_err = 1'b0;
    if (rst) begin
      mq.delete();
      m_pat = 8'b0000_1011;
      m_len = 4;
      m_ovl = 1'b0;
      m_cnt = 0;
    end else if (ld) begin
      if (clen >= 1 && clen <= 8) begin
        m_pat = cpat;
        m_len = int'(clen);
        m_ovl = covl;
        mq.delete();
      end else begin
        exp_err = 1'b1;
      end
    end else if (v) begin
      mq.push_back(xb);
      n = mq.size();
      if (n >= m_len) begin
        hitm = 1'b1;
        for (int i = 0; i < m_len; i++) begin
          if (mq[n - m_len + i] != m_pat[m_len - 1 - i]) hitm = 1'b0;
        end
        if (hitm) begin
          exp_z = 1'b1;
          if (m_cnt < 65535) m_cnt++;
          if (!m_ovl) mq.delete();
        end
      end
      if (mq.size() > 8) void'(mq.pop_front());
    end
    exp_cnt = CntEn ? 16'(m_cnt) : 16'd0;
  endtask

  task automatic step(input bit rst, input bit v, input bit xb, input bit ld,
                      input bit [3:0] clen, input bit [7:0] cpat, input bit covl);
    reset           = rst;
    bus.in_valid    = v;
    bus.x           = xb;
    bus.cfg_load    = ld;
    bus.cfg_len     = clen;
    bus.cfg_pattern = cpat;
    bus.cfg_overlap = covl;
    model_step(rst, ld, clen, cpat, covl, v, xb);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 4'd3, 8'hFF, 1);
    total++; if (bus.z !== 1'b0) begin bad++; $display("FAIL reset_z got=%b exp=0", bus.z); end
    total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.cfg_err); end
    total++; if (bus.match_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.match_cnt); end
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_default();
    bit [6:0] bits = 7'b1011011;
    bit [6:0] zexp = 7'b0001000;
    for (int i = 0; i < 7; i++) begin
      step(0, 1, bits[6-i], 0, 0, 0, 0);
      total++;
      if (bus.z !== zexp[6-i]) begin bad++; $display("FAIL default_z bit=%0d got=%b exp=%b", i + 1, bus.z, zexp[6-i]); end
    end
    total++;
    if (bus.match_cnt !== (CntEn ? 16'd1 : 16'd0)) begin
      bad++; $display("FAIL default_cnt got=%0d exp=%0d", bus.match_cnt, CntEn ? 1 : 0);
    end
  endtask

  task automatic test_overlap();
    bit [6:0] bits = 7'b1011011;
    bit [6:0] zexp = 7'b0001001;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 4'd4, 8'b0000_1011, 1);
    total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL ovl_load_err got=%b exp=0", bus.cfg_err); end
    for (int i = 0; i < 7; i++) begin
      step(0, 1, bits[6-i], 0, 0, 0, 0);
      total++;
      if (bus.z !== zexp[6-i]) begin bad++; $display("FAIL overlap_z bit=%0d got=%b exp=%b", i + 1, bus.z, zexp[6-i]); end
    end
    total++;
    if (bus.match_cnt !== (CntEn ? 16'd2 : 16'd0)) begin
      bad++; $display("FAIL overlap_cnt got=%0d exp=%0d", bus.match_cnt, CntEn ? 2 : 0);
    end
  endtask

  task automatic test_stall();
    bit [7:0] vv   = 8'b11000111;
    bit [7:0] zexp = 8'b00000111;
    step(0, 0, 0, 1, 4'd3, 8'b0000_0111, 1);
    for (int i = 0; i < 8; i++) begin
      step(0, vv[7-i], vv[7-i], 0, 4'd9, 8'hAA, 0);
      total++;
      if (bus.z !== zexp[7-i]) begin bad++; $display("FAIL stall_z cyc=%0d got=%b exp=%b", i, bus.z, zexp[7-i]); end
    end
  endtask

  task automatic test_bad_load();
    step(0, 0, 0, 1, 4'd4, 8'b0000_1011, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 4'd0, 8'hFF, 1);
    total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL badload0_err got=%b exp=1", bus.cfg_err); end
    total++; if (bus.z !== 1'b0) begin bad++; $display("FAIL badload0_z got=%b exp=0", bus.z); end
    step(0, 1, 1, 1, 4'd9, 8'hFF, 1);
    total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL badload9_err got=%b exp=1", bus.cfg_err); end
    step(0, 1, 1, 0, 0, 0, 0);
    total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL err_pulse got=%b exp=0", bus.cfg_err); end
    total++; if (bus.z !== 1'b0) begin bad++; $display("FAIL drop_z got=%b exp=0", bus.z); end
    step(0, 1, 1, 0, 0, 0, 0);
    total++; if (bus.z !== 1'b1) begin bad++; $display("FAIL after_bad_z got=%b exp=1", bus.z); end
  endtask

  task automatic test_saturate();
    step(0, 0, 0, 0, 0, 0, 0);
    bus2.cfg_load    = 1'b1;
    bus2.in_valid    = 1'b1;
    bus2.x           = 1'b0;
    bus2.cfg_len     = 4'd1;
    bus2.cfg_pattern = 8'b0000_0001;
    bus2.cfg_overlap = 1'b1;
    @(posedge clk); #1;
    bus2.cfg_load = 1'b0;
    bus2.x        = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      total++;
      if (bus2.z !== 1'b1) begin bad++; $display("FAIL sat_z k=%0d got=%b exp=1", k, bus2.z); end
      total++;
      if (bus2.match_cnt !== (CntEn ? 2'((k > 3) ? 3 : k) : 2'd0)) begin
        bad++; $display("FAIL sat_cnt k=%0d got=%0d exp=%0d", k, bus2.match_cnt, CntEn ? ((k > 3) ? 3 : k) : 0);
      end
    end
    bus2.in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (bus2.z !== 1'b0) begin bad++; $display("FAIL sat_idle_z got=%b exp=0", bus2.z); end
  endtask

  task automatic test_reset_mid();
    bit [3:0] bits = 4'b1011;
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    total++; if (bus.match_cnt !== 16'd0) begin bad++; $display("FAIL midrst_cnt got=%0d exp=0", bus.match_cnt); end
    step(0, 1, 1, 0, 0, 0, 0);
    total++; if (bus.z !== 1'b0) begin bad++; $display("FAIL midrst_z got=%b exp=0", bus.z); end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, bits[3-i], 0, 0, 0, 0);
      total++;
      if (bus.z !== (i == 3)) begin bad++; $display("FAIL postrst_z bit=%0d got=%b exp=%b", i + 1, bus.z, i == 3); end
    end
  endtask

  task automatic test_random();
    bit r, v, xb, ld, covl;
    bit [3:0] clen;
    bit [7:0] cpat;
    for (int c = 0; c < 800; c++) begin
      r    = ($urandom_range(0, 149) == 0);
      ld   = ($urandom_range(0, 24) == 0);
      clen = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      cpat = 8'($urandom);
      covl = 1'($urandom);
      v    = ($urandom_range(0, 3) != 0);
      xb   = 1'($urandom);
      step(r, v, xb, ld, clen, cpat, covl);
      total++;
      if (bus.z !== exp_z) begin bad++; $display("FAIL rand_z cyc=%0d got=%b exp=%b", c, bus.z, exp_z); end
      total++;
      if (bus.cfg_err !== exp_err) begin bad++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", c, bus.cfg_err, exp_err); end
      total++;
      if (bus.match_cnt !== exp_cnt) begin bad++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", c, bus.match_cnt, exp_cnt); end
    end
  endtask

  initial begin
    reset            = 1'b1;
    bus.in_valid     = 1'b0;
    bus.x            = 1'b0;
    bus.cfg_load     = 1'b0;
    bus.cfg_len      = '0;
    bus.cfg_pattern  = '0;
    bus.cfg_overlap  = 1'b0;
    bus2.in_valid    = 1'b0;
    bus2.x           = 1'b0;
    bus2.cfg_load    = 1'b0;
    bus2.cfg_len     = '0;
    bus2.cfg_pattern = '0;
    bus2.cfg_overlap = 1'b0;
    #2;
    test_reset();
    test_default();
    test_overlap();
    test_stall();
    test_bad_load();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_detector_prog.md
# seq_detector_prog

Runtime-programmable serial pattern detector for 1..MAX_LEN-bit patterns with selectable overlapping or non-overlapping detection. It accepts a valid-qualified serial bit stream and raises a registered Moore-style match pulse, and it optionally maintains a saturating match counter. This is the general-purpose detector in the FSMs library; its reset configuration reproduces the fixed 1011 non-overlapping detector.

## Interface
- MAX_LEN, 8: longest supported pattern in bits; must be at least 2.
- DEF_PATTERN, 8'b0000_1011: pattern loaded at reset, MAX_LEN bits wide, right-aligned.
- DEF_LEN, 4: pattern length loaded at reset.
- DEF_OVERLAP, 0: overlap mode loaded at reset.
- CNT_W, 16: width of the match counter.
- Derived: LEN_W = $clog2(MAX_LEN+1).

Ports:
- clk  in  1  sole clock; rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  `x` is sampled on this edge.
- x  in  1  serial data bit.
- cfg_load  in  1  one-cycle strobe that captures the cfg_* inputs.
- cfg_pattern  in  MAX_LEN  new pattern, right-aligned.
- cfg_len  in  LEN_W  new length; legal range is 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- z  out  1  match pulse (registered).
- cfg_err  out  1  one-cycle pulse when a load is rejected.
- match_cnt  out  CNT_W  saturating count of matches.

## Operation
- Internal state:
  - `hist`: MAX_LEN-bit history shift register.
  - `fill`: count of valid history bits, saturating at MAX_LEN.
  - Active configuration: `pat`, `len`, `ovl`.
- Bit order: the first-received bit of a pattern is `pattern[len-1]`. Each accepted bit shifts left into `hist[0]`.
- An accepted bit is a cycle with in_valid=1 and cfg_load=0.
- Match condition: `{hist[len-2:0], x} == pat[len-1:0]` AND `fill >= len-1`. The condition is evaluated on the accepted bit itself.
- On a match:
  - Overlap mode: `fill` increments normally, so trailing bits can start the next match.
  - Non-overlap mode: `fill` clears to 0, so the next match needs `len` fresh bits.
- cfg_load with 1 <= cfg_len <= MAX_LEN:
  - Capture the pattern, length and overlap mode.
  - Clear `hist` and `fill`.
  - The x bit presented on that cycle is dropped, even if in_valid=1.
- cfg_load with cfg_len = 0 or cfg_len > MAX_LEN:
  - The configuration is unchanged, and `hist`/`fill` are untouched.
  - cfg_err pulses.
  - x is still dropped.
- Arithmetic:
  - `fill` saturates at MAX_LEN.
  - match_cnt increments by 1 per match and saturates at 2^CNT_W-1; it never wraps.
- Mode or pattern changes take effect only through cfg_load. The cfg_* inputs are ignored otherwise.

## Timing
- Reset (synchronous, asserted at a rising edge) sets:
  - z=0, cfg_err=0, match_cnt=0;
  - hist=0, fill=0;
  - pat=DEF_PATTERN, len=DEF_LEN, ovl=DEF_OVERLAP.
- Reset has priority over cfg_load and in_valid. Asserting reset mid-pattern discards the partial match.
- Latency: z is high for the one cycle following the edge that accepted the completing bit.
- Consecutive matches in overlap mode (for example pattern 1, or 11 with 1111) keep z high on back-to-back cycles.
- z is 0 in any cycle following an edge with no accepted bit; in_valid=0 stalls without losing history.
- match_cnt updates on the same edge that sets z.
- cfg_err is high in the cycle after the rejected load.
- A len=1 pattern matches on the first accepted bit after a load (fill >= 0).

## Configuration
- `SEQ_DETECTOR_MATCH_COUNT_EN` defined: match_cnt is implemented as specified.
- Undefined: the counter logic is omitted and match_cnt is tied to 0. z, cfg_err and detection behaviour are identical in both builds.

## Test plan
- Reset defaults (1011, non-overlap); feed accepted bits 1,0,1,1,0,1,1 -> z high exactly once, in the cycle after bit 4; match_cnt=1.
- cfg_load pattern 1011, len 4, overlap=1; feed 1,0,1,1,0,1,1 -> z after bit 4 and after bit 7; match_cnt=2.
- Load pattern 111, len 3, overlap=1; feed five 1s with in_valid low for 3 cycles between bits 2 and 3 -> z after bits 3, 4 and 5 only; z=0 during the stall.
- cfg_load with cfg_len=0, then with cfg_len=MAX_LEN+1 -> cfg_err pulses each time; the 1011 pattern still matches afterwards. A cfg_load coinciding with in_valid=1 drops that bit.
- Build CNT_W=2 with overlap pattern 1, len 1; feed six 1s -> match_cnt reaches 3 and holds.
- Feed 1,0,1, assert reset for one cycle, then feed 1 -> no z. A full 1,0,1,1 afterwards gives z once.
